// File: rtl/pedestrian_lanes_if.sv
// Bundle of the pedestrian mover's control inputs and lane-state outputs.
// The driver side uses the master modport and the mover uses the slave modport.
interface pedestrian_lanes_if #(
  parameter int N_PED = 4,
  parameter int W     = 8,
  parameter int CNT_W = 8
);
  logic               can_move;
  logic               freeze;
  logic [N_PED-1:0]   ped_en;
  logic [N_PED*W-1:0] y;
  logic               move_p;
  logic [N_PED-1:0]   dead;
  logic [CNT_W-1:0]   dead_count;

  modport master (
    output can_move, freeze, ped_en,
    input  y, move_p, dead, dead_count
  );

  modport slave (
    input  can_move, freeze, ped_en,
    output y, move_p, dead, dead_count
  );
endinterface

// File: rtl/pedestrian_lanes.sv
// Moves N_PED independent pedestrians vertically on each accepted tick, either
// wrapping at the bottom or bouncing, and counts bottom-edge events with saturation.
module pedestrian_lanes #(
  parameter int N_PED     = 4,
  parameter int W         = 8,
  parameter int Y_MAX     = 190,
  parameter int STEP      = 3,
  parameter int START_GAP = 48,
  parameter int MODE      = 0,
  parameter int CNT_W     = 8
) (
  input logic              clk,
  input logic              reset,
  pedestrian_lanes_if.slave bus
);

  localparam logic [W:0] Y_MAX_X = (W+1)'(Y_MAX);
  localparam logic [W:0] STEP_X  = (W+1)'(STEP);
  localparam int         SUM_W   = CNT_W + $clog2(N_PED + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  if (Y_MAX + STEP >= (2 ** W)) begin : g_chk_range
    $error("Y_MAX+STEP must fit in W bits");
  end
  if ((N_PED - 1) * START_GAP > Y_MAX) begin : g_chk_gap
    $error("reset stagger exceeds Y_MAX");
  end
  if (STEP < 1) begin : g_chk_step
    $error("STEP must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               tick_s;
  logic [W-1:0]       y_r   [N_PED];
  logic [W-1:0]       y_s   [N_PED];
  logic [W:0]         sum_s [N_PED];
  logic [W:0]         diff_s[N_PED];
  logic [N_PED-1:0]   dir_r, dir_s;
  logic [N_PED-1:0]   dead_r, dead_s;
  logic               move_p_r;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [SUM_W-1:0]   cnt_sum_s;

  function automatic logic [SUM_W-1:0] popcount(input logic [N_PED-1:0] v);
    logic [SUM_W-1:0] c;
    c = {SUM_W{1'b0}};
    for (int k = 0; k < N_PED; k++) begin
      c = c + SUM_W'(v[k]);
    end
    return c;
  endfunction

  // Lane position arithmetic is widened by one bit so the edge compares cannot overflow.
  for (genvar g = 0; g < N_PED; g++) begin : g_lane
    assign sum_s[g]              = {1'b0, y_r[g]} + STEP_X;
    assign diff_s[g]             = {1'b0, y_r[g]} - STEP_X;
    assign bus.y[g*W +: W]       = y_r[g];
  end

  assign bus.move_p     = move_p_r;
  assign bus.dead       = dead_r;
  assign bus.dead_count = cnt_r;

  // Control FSM next state and tick acceptance; freeze outranks can_move.
  always_comb begin
    state_s = state_r;
    tick_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.can_move && !bus.freeze) begin
          state_s = RUN;
          tick_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.freeze) begin
          state_s = FROZEN;
        end else begin
          state_s = RUN;
          tick_s  = bus.can_move;
        end
      end
      FROZEN: begin
        if (!bus.freeze) begin
          state_s = RUN;
        end else begin
          state_s = FROZEN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Per-lane next position, direction (1 = up) and dead event.
  always_comb begin
    for (int i = 0; i < N_PED; i++) begin
      y_s[i]    = y_r[i];
      dir_s[i]  = dir_r[i];
      dead_s[i] = 1'b0;
      if (tick_s && bus.ped_en[i]) begin
        if (MODE == 0) begin
          if ({1'b0, y_r[i]} > Y_MAX_X) begin
            y_s[i]    = {W{1'b0}};
            dead_s[i] = 1'b1;
          end else begin
            y_s[i] = sum_s[i][W-1:0];
          end
        end else if (!dir_r[i]) begin
          if (sum_s[i] > Y_MAX_X) begin
            y_s[i]    = Y_MAX_X[W-1:0];
            dir_s[i]  = 1'b1;
            dead_s[i] = 1'b1;
          end else begin
            y_s[i] = sum_s[i][W-1:0];
          end
        end else begin
          if ({1'b0, y_r[i]} < STEP_X) begin
            y_s[i]   = {W{1'b0}};
            dir_s[i] = 1'b0;
          end else begin
            y_s[i] = diff_s[i][W-1:0];
          end
        end
      end else begin
        y_s[i] = y_r[i];
      end
    end
  end

  // Saturating accumulation of this edge's dead events.
  always_comb begin
    cnt_sum_s = {{(SUM_W-CNT_W){1'b0}}, cnt_r} + popcount(dead_s);
    if (cnt_sum_s > CNT_MAX) begin
      cnt_s = CNT_MAX[CNT_W-1:0];
    end else begin
      cnt_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      dir_r    <= {N_PED{1'b0}};
      dead_r   <= {N_PED{1'b0}};
      move_p_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      for (int i = 0; i < N_PED; i++) begin
        y_r[i] <= W'(i * START_GAP);
      end
    end else begin
      state_r  <= state_s;
      dir_r    <= dir_s;
      dead_r   <= dead_s;
      cnt_r    <= cnt_s;
      if (tick_s) begin
        move_p_r <= 1'b1;
      end else begin
        move_p_r <= move_p_r;
      end
      for (int i = 0; i < N_PED; i++) begin
        y_r[i] <= y_s[i];
      end
    end
  end

endmodule
